// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg
//   Shared definitions for the interrupt front-end: FSM state encoding,
//   default handler vector constants and the irq_id width helper.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_SVC  = 2'b10
    } irq_state_e;

    localparam logic [31:0] DEF_NMI_VECTOR    = 32'h0000_0020;
    localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_0040;
    localparam logic [31:0] DEF_VECTOR_STRIDE = 32'd16;

    // Width of an IRQ index; never below one bit.
    function automatic int irq_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// irq_priority_enc
//   Combinational fixed-priority encoder, lowest set index wins.
//   Ports:
//     req   [NUM_IRQ] candidate requests (already masked)
//     id    [IDW]     index of the winning request (0 when none)
//     valid           at least one request is set
module irq_priority_enc #(
    parameter int NUM_IRQ = 8,
    parameter int IDW     = 3
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDW-1:0]     id,
    output logic               valid
);

    // Scan high-to-low so the lowest set index is the last assignment.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = IDW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Front-end of the MIPS interrupt path. Edge-detects NUM_IRQ maskable
//   lines and one NMI into pending registers, masks/gates them, picks the
//   lowest-index request and hands it to the interrupt state stage through
//   a three-state IDLE/REQ/SVC machine with registered outputs.
//   Build option: IRQ_INPUT_SYNC_EN adds a 2-flop synchronizer on irq_in
//   and nmi_in ahead of edge detection (request latency 4 instead of 2).
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     irq_in, nmi_in      external requests (edge-detected)
//     mask_we/mask_wdata  mask register write (1 = blocked)
//     ie_we/ie_wdata      global enable write
//     respond             acknowledge from state stage (rising edge)
//     eoi                 handler completion pulse
//     interrupt           maskable request out
//     non_maskable_int    NMI request out
//     busy                ~ie
//     irq_id, vector      ID / handler address of current request
//     pending, mask_q     status
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_IRQ       = 8,
    parameter logic [31:0] VECTOR_BASE   = DEF_VECTOR_BASE,
    parameter logic [31:0] VECTOR_STRIDE = DEF_VECTOR_STRIDE,
    parameter logic [31:0] NMI_VECTOR    = DEF_NMI_VECTOR,
    localparam int         IDW           = irq_id_w(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               nmi_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               ie_we,
    input  logic               ie_wdata,
    input  logic               respond,
    input  logic               eoi,
    output logic               interrupt,
    output logic               non_maskable_int,
    output logic               busy,
    output logic [IDW-1:0]     irq_id,
    output logic [31:0]        vector,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask_q
);

    logic [NUM_IRQ-1:0] irq_src, irq_prev;
    logic               nmi_src, nmi_prev;
    logic               nmi_pend;
    logic               ie;
    logic               respond_prev;
    logic               srv_nmi;     // current request is the NMI
    irq_state_e         state;

`ifdef IRQ_INPUT_SYNC_EN
    logic [NUM_IRQ-1:0] irq_s1, irq_s2;
    logic               nmi_s1, nmi_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
            nmi_s1 <= 1'b0;
            nmi_s2 <= 1'b0;
        end else begin
            irq_s1 <= irq_in;
            irq_s2 <= irq_s1;
            nmi_s1 <= nmi_in;
            nmi_s2 <= nmi_s1;
        end
    end

    assign irq_src = irq_s2;
    assign nmi_src = nmi_s2;
`else
    assign irq_src = irq_in;
    assign nmi_src = nmi_in;
`endif

    wire [NUM_IRQ-1:0] irq_rise  = irq_src & ~irq_prev;
    wire               nmi_rise  = nmi_src & ~nmi_prev;
    wire               resp_edge = respond & ~respond_prev;
    wire               ack       = (state == ST_REQ) && resp_edge;

    wire [NUM_IRQ-1:0] one_hot  = {{(NUM_IRQ-1){1'b0}}, 1'b1};
    wire [NUM_IRQ-1:0] irq_clr  = (ack && !srv_nmi) ? (one_hot << irq_id) : '0;
    wire               nmi_clr  = ack && srv_nmi;

    logic [IDW-1:0] sel_id;
    logic           sel_vld;

    irq_priority_enc #(.NUM_IRQ(NUM_IRQ), .IDW(IDW)) u_enc (
        .req   (pending & ~mask_q),
        .id    (sel_id),
        .valid (sel_vld)
    );

    assign busy = ~ie;

    // Edge detect, pending, and programmable registers. Set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev     <= '0;
            nmi_prev     <= 1'b0;
            pending      <= '0;
            nmi_pend     <= 1'b0;
            mask_q       <= '1;
            ie           <= 1'b0;
            respond_prev <= 1'b0;
        end else begin
            irq_prev     <= irq_src;
            nmi_prev     <= nmi_src;
            pending      <= (pending & ~irq_clr) | irq_rise;
            nmi_pend     <= (nmi_pend & ~nmi_clr) | nmi_rise;
            respond_prev <= respond;
            if (mask_we) mask_q <= mask_wdata;
            if (ie_we)   ie     <= ie_wdata;
        end
    end

    // Request FSM. The request stays high through SVC until eoi because the
    // downstream stage needs it held until the handler is done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            interrupt        <= 1'b0;
            non_maskable_int <= 1'b0;
            irq_id           <= '0;
            vector           <= '0;
            srv_nmi          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (nmi_pend) begin
                        srv_nmi          <= 1'b1;
                        irq_id           <= '0;
                        vector           <= NMI_VECTOR;
                        non_maskable_int <= 1'b1;
                        state            <= ST_REQ;
                    end else if (ie && sel_vld) begin
                        srv_nmi   <= 1'b0;
                        irq_id    <= sel_id;
                        vector    <= VECTOR_BASE + 32'(sel_id) * VECTOR_STRIDE;
                        interrupt <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (resp_edge) state <= ST_SVC;
                end
                ST_SVC: begin
                    if (eoi) begin
                        interrupt        <= 1'b0;
                        non_maskable_int <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

`ifdef IRQ_INPUT_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic       nmi_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ie_we, ie_wdata;
    logic       respond, eoi;
    logic       interrupt, non_maskable_int, busy;
    logic [2:0] irq_id;
    logic [31:0] vector;
    logic [7:0] pending, mask_q;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .nmi_in(nmi_in),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .ie_we(ie_we),
        .ie_wdata(ie_wdata), .respond(respond), .eoi(eoi),
        .interrupt(interrupt), .non_maskable_int(non_maskable_int),
        .busy(busy), .irq_id(irq_id), .vector(vector),
        .pending(pending), .mask_q(mask_q)
    );

    typedef struct {
        logic        nmi;
        logic [2:0]  id;
        logic [31:0] vec;
    } exp_req_t;

    exp_req_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_req_t mk(input logic n, input logic [2:0] id, input logic [31:0] v);
        exp_req_t e;
        e.nmi = n; e.id = id; e.vec = v;
        return e;
    endfunction

    // Scoreboard: each new request presented by the DUT must match the head.
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        logic req_now;
        exp_req_t e;
        req_now = interrupt | non_maskable_int;
        if (req_now && !req_prev) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_req", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_nmi", {31'd0, non_maskable_int}, {31'd0, e.nmi});
                chk("sb_int", {31'd0, interrupt}, {31'd0, ~e.nmi});
                if (!e.nmi) chk("sb_id", {29'd0, irq_id}, {29'd0, e.id});
                chk("sb_vec", vector, e.vec);
            end
        end
        req_prev = req_now;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_irq(input logic [7:0] m, input logic n);
        irq_in = m; nmi_in = n;
        tick();
        irq_in = '0; nmi_in = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int i;
        for (i = 0; i < 20; i++) begin
            if (interrupt || non_maskable_int) break;
            tick();
        end
        if (i == 20) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_respond();
        respond = 1'b1; tick(); respond = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic wr_cfg(input logic ie_v, input logic [7:0] m);
        ie_we = 1'b1; ie_wdata = ie_v; mask_we = 1'b1; mask_wdata = m;
        tick();
        ie_we = 1'b0; mask_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; nmi_in = 1'b0; mask_we = 1'b0; mask_wdata = '0;
        ie_we = 1'b0; ie_wdata = 1'b0; respond = 1'b0; eoi = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_int", {31'd0, interrupt}, 32'd0);
        chk("rst_nmi", {31'd0, non_maskable_int}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_mask", {24'd0, mask_q}, 32'hff);
        chk("rst_pend", {24'd0, pending}, 32'd0);
        chk("rst_vec", vector, 32'd0);

        // Single IRQ 3, latency, ack and eoi
        wr_cfg(1'b1, 8'h00);
        chk("busy_ie1", {31'd0, busy}, 32'd0);
        sb.push_back(mk(1'b0, 3'd3, 32'h70));
        irq_in = 8'h08;
        tick(LAT - 1);
        irq_in = '0;
        chk("lat_pend", {24'd0, pending}, 32'h08);
        chk("lat_noint", {31'd0, interrupt}, 32'd0);
        tick();
        chk("lat_int", {31'd0, interrupt}, 32'd1);
        chk("irq3_id", {29'd0, irq_id}, 32'd3);
        chk("irq3_vec", vector, 32'h70);
        tick(2);
        chk("req_hold", {31'd0, interrupt}, 32'd1);
        do_respond();
        chk("ack_clr", {24'd0, pending}, 32'd0);
        chk("svc_hold", {31'd0, interrupt}, 32'd1);
        do_eoi();
        chk("eoi_drop", {31'd0, interrupt}, 32'd0);
        tick(2);
        chk("idle_quiet", {31'd0, interrupt}, 32'd0);

        // Simultaneous IRQ 5 and 2: lowest index first
        sb.push_back(mk(1'b0, 3'd2, 32'h60));
        sb.push_back(mk(1'b0, 3'd5, 32'h90));
        pulse_irq(8'h24, 1'b0);
        wait_req("prio_a");
        chk("prio_a_id", {29'd0, irq_id}, 32'd2);
        do_respond();
        chk("prio_pend", {24'd0, pending}, 32'h20);
        do_eoi();
        wait_req("prio_b");
        chk("prio_b_vec", vector, 32'h90);
        do_respond(); do_eoi();

        // IRQ 1 and NMI together: NMI first
        sb.push_back(mk(1'b1, 3'd0, 32'h20));
        sb.push_back(mk(1'b0, 3'd1, 32'h50));
        pulse_irq(8'h02, 1'b1);
        wait_req("nmi_a");
        chk("nmi_a_nmi", {31'd0, non_maskable_int}, 32'd1);
        chk("nmi_a_int", {31'd0, interrupt}, 32'd0);
        do_respond(); do_eoi();
        wait_req("nmi_b");
        chk("nmi_b_id", {29'd0, irq_id}, 32'd1);
        do_respond(); do_eoi();

        // Masked IRQ 4 stays pending until unmasked
        wr_cfg(1'b1, 8'h10);
        pulse_irq(8'h10, 1'b0);
        tick(4);
        chk("mask_pend", {24'd0, pending}, 32'h10);
        chk("mask_noint", {31'd0, interrupt}, 32'd0);
        sb.push_back(mk(1'b0, 3'd4, 32'h80));
        wr_cfg(1'b1, 8'h00);
        chk("unmask_noint", {31'd0, interrupt}, 32'd0);
        tick();
        chk("unmask_int", {31'd0, interrupt}, 32'd1);
        do_respond(); do_eoi();

        // ie=0 blocks maskable, NMI still goes through
        wr_cfg(1'b0, 8'h00);
        chk("ie0_busy", {31'd0, busy}, 32'd1);
        pulse_irq(8'h01, 1'b0);
        tick(4);
        chk("ie0_pend", {24'd0, pending}, 32'h01);
        chk("ie0_noint", {31'd0, interrupt}, 32'd0);
        sb.push_back(mk(1'b1, 3'd0, 32'h20));
        pulse_irq(8'h00, 1'b1);
        wait_req("ie0_nmi");
        chk("ie0_nmi_out", {31'd0, non_maskable_int}, 32'd1);
        do_respond(); do_eoi();

        // Reset while in SVC
        sb.push_back(mk(1'b0, 3'd0, 32'h40));
        wr_cfg(1'b1, 8'h00);
        wait_req("svc_req");
        do_respond();
        rst_n = 1'b0;
        #2;
        chk("arst_int", {31'd0, interrupt}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd1);
        chk("arst_vec", vector, 32'd0);
        chk("arst_id", {29'd0, irq_id}, 32'd0);
        chk("arst_pend", {24'd0, pending}, 32'd0);
        chk("arst_mask", {24'd0, mask_q}, 32'hff);
        tick();
        rst_n = 1'b1;
        wr_cfg(1'b1, 8'h00);
        tick(5);
        chk("post_rst_quiet", {31'd0, interrupt | non_maskable_int}, 32'd0);
        sb.push_back(mk(1'b0, 3'd6, 32'hA0));
        pulse_irq(8'h40, 1'b0);
        wait_req("post_rst");
        chk("post_rst_id", {29'd0, irq_id}, 32'd6);
        do_respond(); do_eoi();
        tick(2);

        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
